// File: rtl/trapezoid_integrator_mc.sv
// rtl/trapezoid_integrator_mc.sv - multi-channel saturating trapezoid/rectangle integrator
module trapezoid_integrator_mc #(
    parameter int NCH    = 2,
    parameter int DATA_W = 16,
    parameter int DT_W   = 8,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mode,
    input  logic [DT_W-1:0]         dt,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCH*DATA_W-1:0]   in_data,
    output logic                    busy,
    output logic                    done,
    output logic [NCH*ACC_W-1:0]    acc_out,
    output logic [NCH-1:0]          ovf
);

    localparam int PW = DATA_W + DT_W + 2;
    localparam int XW = ((PW > ACC_W) ? PW : ACC_W) + 1;
    localparam logic signed [XW-1:0] ACC_MAX = {{(XW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [XW-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       mode_q, mode_d;
    logic [DT_W-1:0]            dt_q, dt_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic                       drain_q, drain_d;
    logic                       term_v_q, term_v_d;
    logic                       prod_v_q, prod_v_d;
    logic [NCH-1:0]             psat_q, psat_d;
    logic [NCH-1:0]             ovf_q, ovf_d;
    logic signed [DATA_W-1:0]   prev_q [NCH];
    logic signed [DATA_W-1:0]   prev_d [NCH];
    logic signed [DATA_W:0]     term_q [NCH];
    logic signed [DATA_W:0]     term_d [NCH];
    logic signed [ACC_W-1:0]    prod_q [NCH];
    logic signed [ACC_W-1:0]    prod_d [NCH];
    logic signed [ACC_W-1:0]    acc_q  [NCH];
    logic signed [ACC_W-1:0]    acc_d  [NCH];
    logic signed [DATA_W-1:0]   cur_w  [NCH];
    logic signed [XW-1:0]       prod_w [NCH];
    logic signed [XW-1:0]       sum_w  [NCH];

    logic accept;
    logic start_go;
    logic last_accept;

    // abort outranks both a same-cycle accept and a same-cycle start
    assign accept      = in_valid && in_ready && !abort;
    assign start_go    = (state_q == S_IDLE) && start && !abort;
    assign last_accept = accept && (state_q == S_RUN) && ((cnt_q + LEN_W'(1)) == len_q);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = S_PRIME;
            S_PRIME: if (accept) state_d = S_RUN;
            S_RUN:   if (last_accept) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        in_ready = (state_q == S_PRIME) || (state_q == S_RUN);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        for (int c = 0; c < NCH; c++) begin
            acc_out[c*ACC_W +: ACC_W] = acc_q[c];
        end
        ovf = ovf_q;
    end

    always_comb begin
        mode_d   = mode_q;
        dt_d     = dt_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        drain_d  = (state_q == S_DRAIN) && !drain_q && !abort;
        term_v_d = accept && (state_q == S_RUN);
        prod_v_d = term_v_q && !abort;
        if (start_go) begin
            mode_d = mode;
            dt_d   = dt;
            len_d  = (len < LEN_W'(2)) ? LEN_W'(2) : len;
            cnt_d  = '0;
            ovf_d  = '0;
        end else if (accept) begin
            cnt_d = cnt_q + LEN_W'(1);
        end
        for (int c = 0; c < NCH; c++) begin
            cur_w[c]  = $signed(in_data[c*DATA_W +: DATA_W]);
            prev_d[c] = accept ? cur_w[c] : prev_q[c];
            term_d[c] = mode_q ? (DATA_W+1)'(prev_q[c])
                               : (DATA_W+1)'(prev_q[c]) + (DATA_W+1)'(cur_w[c]);

            prod_w[c] = XW'(term_q[c]) * XW'($signed({1'b0, dt_q}));
            if (!mode_q) begin
                prod_w[c] = prod_w[c] >>> 1;
            end
            if (prod_w[c] > ACC_MAX) begin
                prod_d[c] = ACC_MAX[ACC_W-1:0];
                psat_d[c] = 1'b1;
            end else if (prod_w[c] < ACC_MIN) begin
                prod_d[c] = ACC_MIN[ACC_W-1:0];
                psat_d[c] = 1'b1;
            end else begin
                prod_d[c] = prod_w[c][ACC_W-1:0];
                psat_d[c] = 1'b0;
            end

            sum_w[c] = XW'(acc_q[c]) + XW'(prod_q[c]);
            acc_d[c] = acc_q[c];
            if (start_go) begin
                acc_d[c] = '0;
            end else if (prod_v_q && !abort) begin
                if (sum_w[c] > ACC_MAX) begin
                    acc_d[c] = ACC_MAX[ACC_W-1:0];
                    ovf_d[c] = 1'b1;
                end else if (sum_w[c] < ACC_MIN) begin
                    acc_d[c] = ACC_MIN[ACC_W-1:0];
                    ovf_d[c] = 1'b1;
                end else begin
                    acc_d[c] = sum_w[c][ACC_W-1:0];
                    ovf_d[c] = ovf_q[c] | psat_q[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            mode_q   <= 1'b0;
            dt_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= 1'b0;
            term_v_q <= 1'b0;
            prod_v_q <= 1'b0;
            psat_q   <= '0;
            ovf_q    <= '0;
            for (int c = 0; c < NCH; c++) begin
                prev_q[c] <= '0;
                term_q[c] <= '0;
                prod_q[c] <= '0;
                acc_q[c]  <= '0;
            end
        end else begin
            mode_q   <= mode_d;
            dt_q     <= dt_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            term_v_q <= term_v_d;
            prod_v_q <= prod_v_d;
            psat_q   <= psat_d;
            ovf_q    <= ovf_d;
            for (int c = 0; c < NCH; c++) begin
                prev_q[c] <= prev_d[c];
                term_q[c] <= term_d[c];
                prod_q[c] <= prod_d[c];
                acc_q[c]  <= acc_d[c];
            end
        end
    end

endmodule

// File: tb/tb_trapezoid_integrator_mc.sv
// tb/tb_trapezoid_integrator_mc.sv - scoreboard bench for trapezoid_integrator_mc (ACC_W 32 and 20)
module tb_trapezoid_integrator_mc;

    logic        clk = 1'b0;
    logic        resetb, start, abort, mode, in_valid;
    logic [7:0]  dt;
    logic [15:0] len;
    logic [31:0] in_data;
    logic        ready_a, busy_a, done_a, ready_b, busy_b, done_b;
    logic [63:0] acc_a;
    logic [39:0] acc_b;
    logic [1:0]  ovf_a, ovf_b;

    int tests_run = 0;
    int tests_failed = 0;
    int smp0[$];
    int smp1[$];

    typedef struct {
        longint a0, a1, b0, b1;
        logic [1:0] oa, ob;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    trapezoid_integrator_mc dut_a (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort), .mode(mode),
        .dt(dt), .len(len), .in_valid(in_valid), .in_ready(ready_a), .in_data(in_data),
        .busy(busy_a), .done(done_a), .acc_out(acc_a), .ovf(ovf_a)
    );

    trapezoid_integrator_mc #(.ACC_W(20)) dut_b (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort), .mode(mode),
        .dt(dt), .len(len), .in_valid(in_valid), .in_ready(ready_b), .in_data(in_data),
        .busy(busy_b), .done(done_b), .acc_out(acc_b), .ovf(ovf_b)
    );

    function automatic longint satw(input longint x, input int w, inout logic f);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (x > mx) begin
            f = 1'b1;
            return mx;
        end
        if (x < -mx - 1) begin
            f = 1'b1;
            return -mx - 1;
        end
        return x;
    endfunction

    function automatic void model(input int m, input int d, input int n, input int w,
                                  output longint a0, output longint a1, output logic [1:0] ov);
        longint acc, t, p, c;
        logic f;
        a0 = 0;
        a1 = 0;
        ov = '0;
        for (int ch = 0; ch < 2; ch++) begin
            acc = 0;
            f = 1'b0;
            for (int i = 1; i < n; i++) begin
                p = (ch == 0) ? longint'(smp0[i-1]) : longint'(smp1[i-1]);
                c = (ch == 0) ? longint'(smp0[i])   : longint'(smp1[i]);
                t = (m != 0) ? p * d : ((p + c) * d) >>> 1;
                t = satw(t, w, f);
                acc = satw(acc + t, w, f);
            end
            if (ch == 0) a0 = acc; else a1 = acc;
            ov[ch] = f;
        end
    endfunction

    task automatic run_window(input int m, input int d, input int l, input bit toggle, input bit mid_start);
        int n, idx, cyc, k, s0v, s1v;
        bit acc_now;
        longint x0, x1, y0, y1;
        logic [1:0] ox, oy;
        exp_t e, r;
        n = (l < 2) ? 2 : l;
        model(m, d, n, 32, x0, x1, ox);
        model(m, d, n, 20, y0, y1, oy);
        e.a0 = x0; e.a1 = x1; e.oa = ox;
        e.b0 = y0; e.b1 = y1; e.ob = oy;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; mode = m[0]; dt = d[7:0]; len = l[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 100) begin
            s0v = smp0[idx];
            s1v = smp1[idx];
            in_valid = toggle ? (cyc[0] == 1'b0) : 1'b1;
            in_data  = {s1v[15:0], s0v[15:0]};
            start    = mid_start && (idx == 2);
            acc_now  = in_valid && ready_a;
            @(posedge clk); #1;
            if (acc_now) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        tests_run++;
        if (idx != n) begin
            tests_failed++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", idx, n);
        end
        k = 0;
        for (int j = 1; j <= 8 && k == 0; j++) begin
            @(negedge clk);
            if (done_a) begin
                k = j;
            end else begin
                tests_run++;
                if (ready_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL drain_ready got=%b want=0", ready_a);
                end
            end
        end
        tests_run++;
        if (k != 3) begin
            tests_failed++;
            $display("FAIL done_latency got=%0d want=3", k);
        end
        r = sbq.pop_front();
        tests_run++;
        if (longint'($signed(acc_a[31:0])) !== r.a0 || longint'($signed(acc_a[63:32])) !== r.a1 || ovf_a !== r.oa) begin
            tests_failed++;
            $display("FAIL result32 got=%0d,%0d ovf=%b want=%0d,%0d ovf=%b",
                     $signed(acc_a[31:0]), $signed(acc_a[63:32]), ovf_a, r.a0, r.a1, r.oa);
        end
        tests_run++;
        if (longint'($signed(acc_b[19:0])) !== r.b0 || longint'($signed(acc_b[39:20])) !== r.b1
            || ovf_b !== r.ob || done_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL result20 got=%0d,%0d ovf=%b done=%b want=%0d,%0d ovf=%b done=1",
                     $signed(acc_b[19:0]), $signed(acc_b[39:20]), ovf_b, done_b, r.b0, r.b1, r.ob);
        end
        @(negedge clk);
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_done got done=%b busy=%b ready=%b want 0,0,0", done_a, busy_a, ready_a);
        end
    endtask

    task automatic fill(input int v0, input int v1, input int n);
        smp0 = {};
        smp1 = {};
        for (int i = 0; i < n; i++) begin
            smp0.push_back(v0);
            smp1.push_back(v1);
        end
    endtask

    task automatic test_reset;
        resetb = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; in_valid = 1'b0;
        dt = '0; len = '0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (acc_a !== '0 || acc_b !== '0 || ovf_a !== '0 || done_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state got acc=%h ovf=%b done=%b busy=%b ready=%b want all 0",
                     acc_a, ovf_a, done_a, busy_a, ready_a);
        end
        @(posedge clk); #1;
        resetb = 1'b1;
    endtask

    task automatic test_trapezoid;
        fill(100, -100, 5);
        run_window(0, 4, 5, 1'b0, 1'b0);
        tests_run++;
        if ($signed(acc_a[31:0]) !== 32'sd1600 || $signed(acc_a[63:32]) !== -32'sd1600) begin
            tests_failed++;
            $display("FAIL trap_const got=%0d,%0d want=1600,-1600", $signed(acc_a[31:0]), $signed(acc_a[63:32]));
        end
    endtask

    task automatic test_rectangle;
        smp0 = '{0, 1, 2, 3};
        smp1 = '{-5, 9, 300, -7};
        run_window(1, 2, 4, 1'b0, 1'b0);
        tests_run++;
        if ($signed(acc_a[31:0]) !== 32'sd6) begin
            tests_failed++;
            $display("FAIL rect_ramp got=%0d want=6", $signed(acc_a[31:0]));
        end
    endtask

    task automatic test_floor;
        smp0 = '{-3, -4};
        smp1 = '{3, 4};
        run_window(0, 1, 2, 1'b0, 1'b0);
        tests_run++;
        if ($signed(acc_a[31:0]) !== -32'sd4 || $signed(acc_a[63:32]) !== 32'sd3) begin
            tests_failed++;
            $display("FAIL floor got=%0d,%0d want=-4,3", $signed(acc_a[31:0]), $signed(acc_a[63:32]));
        end
        run_window(0, 1, 0, 1'b0, 1'b0);
        run_window(0, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_saturation;
        fill(32767, 0, 3);
        run_window(0, 255, 3, 1'b0, 1'b0);
        tests_run++;
        if ($signed(acc_b[19:0]) !== 20'sd524287 || ovf_b !== 2'b01) begin
            tests_failed++;
            $display("FAIL sat20 got=%0d ovf=%b want=524287 ovf=01", $signed(acc_b[19:0]), ovf_b);
        end
    endtask

    task automatic test_handshake;
        fill(100, -100, 5);
        run_window(0, 4, 5, 1'b1, 1'b1);
    endtask

    task automatic test_abort;
        fill(7, 7, 4);
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; dt = 8'd1; len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (acc_a !== '0 || ovf_b !== 2'b00 || busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_clears got acc=%h ovf20=%b busy=%b want 0,00,1", acc_a, ovf_b, busy_a);
        end
        in_valid = 1'b1;
        in_data = {16'd7, 16'd7};
        repeat (2) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0 || ready_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_busy got busy=%b ready=%b want 0,0", busy_a, ready_a);
        end
        begin
            bit seen;
            seen = 1'b0;
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                if (done_a || busy_a) seen = 1'b1;
            end
            tests_run++;
            if (seen || acc_a !== '0) begin
                tests_failed++;
                $display("FAIL abort_quiet got done_or_busy=%b acc=%h want 0,0", seen, acc_a);
            end
        end
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_abort_idle got busy=%b want 0", busy_a);
        end
    endtask

    task automatic test_random;
        for (int w = 0; w < 5; w++) begin
            smp0 = {};
            smp1 = {};
            for (int i = 0; i < 10; i++) begin
                smp0.push_back(int'($urandom_range(8000)) - 4000);
                smp1.push_back(int'($urandom_range(65535)) - 32768);
            end
            run_window(int'($urandom_range(1)), int'($urandom_range(255)), int'($urandom_range(8)),
                       bit'($urandom_range(1)), 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; dt = 8'd8; len = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = {16'd1000, 16'd1000};
        repeat (4) begin
            @(posedge clk); #1;
        end
        resetb = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (acc_a !== '0 || acc_b !== '0 || ovf_a !== '0 || busy_a !== 1'b0 || ready_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid got acc=%h ovf=%b busy=%b ready=%b done=%b want all 0",
                     acc_a, ovf_a, busy_a, ready_a, done_a);
        end
        @(posedge clk); #1;
        resetb = 1'b1;
    endtask

    initial begin
        test_reset;
        test_trapezoid;
        test_rectangle;
        test_floor;
        test_saturation;
        test_abort;
        test_handshake;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
